// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction fetch unit.
package fetch_pkg;

    localparam int          DEF_DATA_W     = 16;
    localparam int          DEF_ADDR_W     = 10;
    localparam int          DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_RESET_PC   = 0;

    // Buffered fetch entry at the default widths: instruction word plus its address.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; flush dominates push and pop.
module fetch_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; data needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next-state for pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generator plus prefetch buffer between instruction memory and decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_en,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [DATA_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [DATA_W-1:0]           instr,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic [ADDR_W-1:0]           fetch_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W:0]    credits_used;
    logic              fifo_empty, fifo_full;
    entry_t            push_entry, head_entry;

    // Credits cover both buffered entries and the word still coming back from memory,
    // so a granted request always has a FIFO slot waiting for it.
    assign credits_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign imem_en      = reset && !redirect_valid && (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign fetch_pc     = fetch_pc_q;

    assign push_entry   = '{instr: imem_rdata, pc: inflight_pc_q};
    assign instr_valid  = !fifo_empty;
    assign instr        = head_entry.instr;
    assign instr_pc     = head_entry.pc;

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_valid),
        .push_i  (inflight_q),
        .pop_i   (instr_ready),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Next PC and in-flight tracking; a redirect squashes the outstanding response.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_en) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A response must never land in a full buffer.
    assert property (@(posedge clk) disable iff (!reset)
                     (inflight_q && !redirect_valid) |-> !fifo_full);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: queue-based reference model plus directed scenarios.
module tb_instruction_fetch_unit;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] fetch_pc;
    logic [2:0]    fifo_count;

    logic          reset2;
    logic          imem_en2;
    logic [AW-1:0] imem_addr2;
    logic [DW-1:0] imem_rdata2;
    logic          redirect_valid2;
    logic [AW-1:0] redirect_pc2;
    logic          instr_valid2;
    logic          instr_ready2;
    logic [DW-1:0] instr2;
    logic [AW-1:0] instr_pc2;
    logic [AW-1:0] fetch_pc2;
    logic [2:0]    fifo_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fetch_pc(fetch_pc), .fifo_count(fifo_count)
    );

    instruction_fetch_unit #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC('h3FE)
    ) dut_wrap (
        .clk(clk), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2),
        .instr_pc(instr_pc2), .fetch_pc(fetch_pc2), .fifo_count(fifo_count2)
    );

    // Instruction memories: mem[a] = a + 16'h100, one-cycle read latency.
    always @(posedge clk) if (imem_en)  imem_rdata  <= 16'(imem_addr)  + 16'h0100;
    always @(posedge clk) if (imem_en2) imem_rdata2 <= 16'(imem_addr2) + 16'h0100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered pcs, one outstanding request, next fetch address.
    logic [AW-1:0] mq[$];
    bit            m_infl;
    logic [AW-1:0] m_infl_pc;
    logic [AW-1:0] m_pc;

    function automatic bit m_issue();
        return reset && !redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = '0;
        end else begin
            bit iss;
            iss = m_issue();
            if (redirect_valid) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc;
            end else begin
                if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                m_infl = iss;
                if (iss) begin
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + AW'(1);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_imem_en", 32'(imem_en), 32'(m_issue()));
        if (m_issue()) chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("m_fetch_pc", 32'(fetch_pc), 32'(m_pc));
        chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("m_instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_instr_pc", 32'(instr_pc), 32'(mq[0]));
            chk("m_instr", 32'(instr), 32'(mq[0]) + 32'h100);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] wrap_exp [4];
        int pulses;
        wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        reset = 1'b0; reset2 = 1'b0;
        instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        step(2);

        // Reset state
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);

        // Streaming after release with ready high
        reset = 1'b1;
        #1;
        chk("t1_en_c0", 32'(imem_en), 32'd1);
        chk("t1_addr_c0", 32'(imem_addr), 32'd0);
        step(1);
        chk("t1_valid_c1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t1_valid", 32'(instr_valid), 32'd1);
            chk("t1_pc", 32'(instr_pc), 32'(i));
            chk("t1_instr", 32'(instr), 32'h100 + 32'(i));
        end

        // Back-pressure: buffer fills, then drains in order
        reset = 1'b0; instr_ready = 1'b0;
        step(2);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_en) pulses++;
            step(1);
        end
        chk("t2_pulses", 32'(pulses), 32'd4);
        chk("t2_count", 32'(fifo_count), 32'd4);
        chk("t2_fetch_pc", 32'(fetch_pc), 32'd4);
        chk("t2_head_pc", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_valid", 32'(instr_valid), 32'd1);
            chk("t2_drain_pc", 32'(instr_pc), 32'(i));
            step(1);
        end
        step(3);

        // Redirect with 3 buffered entries and one in flight
        reset = 1'b0; instr_ready = 1'b0;
        step(2);
        reset = 1'b1;
        step(4);
        chk("t3_count_pre", 32'(fifo_count), 32'd3);
        chk("t3_en_pre", 32'(imem_en), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 10'h200;
        step(1);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        chk("t3_count_flush", 32'(fifo_count), 32'd0);
        chk("t3_en", 32'(imem_en), 32'd1);
        chk("t3_addr", 32'(imem_addr), 32'h200);
        chk("t3_valid_r1", 32'(instr_valid), 32'd0);
        step(1);
        chk("t3_valid_r2", 32'(instr_valid), 32'd0);
        step(1);
        chk("t3_valid_r3", 32'(instr_valid), 32'd1);
        chk("t3_pc_r3", 32'(instr_pc), 32'h200);
        chk("t3_instr_r3", 32'(instr), 32'h300);
        step(1);
        chk("t3_pc_r4", 32'(instr_pc), 32'h201);

        // Wrap-around from RESET_PC = 3FE
        reset2 = 1'b1;
        step(2);
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid", 32'(instr_valid2), 32'd1);
            chk("t4_pc", 32'(instr_pc2), 32'(wrap_exp[i]));
            chk("t4_instr", 32'(instr2), 32'(wrap_exp[i]) + 32'h100);
            step(1);
        end

        // Redirect with a same-cycle pop, then a second redirect that wins
        chk("t5_valid_pre", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 10'h120;
        step(1);
        chk("t5_en_mid", 32'(imem_en), 32'd0);
        chk("t5_count_mid", 32'(fifo_count), 32'd0);
        redirect_pc = 10'h050;
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("t5_en", 32'(imem_en), 32'd1);
        chk("t5_addr", 32'(imem_addr), 32'h050);
        step(1);
        chk("t5_valid_gap", 32'(instr_valid), 32'd0);
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_valid", 32'(instr_valid), 32'd1);
            chk("t5_pc", 32'(instr_pc), 32'h050 + 32'(i));
            step(1);
        end

        // Asynchronous reset mid-stream with the buffer half full
        reset = 1'b0; instr_ready = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        chk("t6_count_pre", 32'(fifo_count), 32'd2);
        chk("t6_valid_pre", 32'(instr_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid_async", 32'(instr_valid), 32'd0);
        chk("t6_en_async", 32'(imem_en), 32'd0);
        chk("t6_count_async", 32'(fifo_count), 32'd0);
        chk("t6_fetch_pc_async", 32'(fetch_pc), 32'd0);
        step(1);
        reset = 1'b1; instr_ready = 1'b1;
        #1;
        chk("t6_en_restart", 32'(imem_en), 32'd1);
        chk("t6_addr_restart", 32'(imem_addr), 32'd0);
        step(2);
        chk("t6_valid_restart", 32'(instr_valid), 32'd1);
        chk("t6_pc_restart", 32'(instr_pc), 32'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
